// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode 7-segment driver.
// scan_clk is a slow square wave that is sampled in the clk_in domain; each of
// its rising edges advances the display by one digit. A new value is staged in
// a pending frame and only becomes visible at the start of the next frame, so a
// frame is never shown half old and half new. Between digits all anodes are
// switched off for a short gap to prevent ghosting. Leading zeros can be
// suppressed.
module seg7_scan_driver #(
    parameter int BLANK_CYCLES = 8,
    parameter int CNT_W        = 8
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        scan_clk,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel
);

    typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic sync_a;
    logic sync_q;
    logic edge_q;
    logic tick;
    logic frame_start;

    logic [15:0] pending_val;
    logic [3:0]  pending_dp;
    logic        pending_lz;
    logic [15:0] active_val;
    logic [3:0]  active_dp;
    logic        active_lz;

    logic [3:0]  upper_zero;
    logic [15:0] shifted_val;
    logic [3:0]  nibble;
    logic        lz_blank;
    logic [6:0]  hex_seg;
    logic [3:0]  show_an;
    logic [6:0]  show_seg;
    logic        show_dp;

    // Two-stage synchroniser for scan_clk plus an edge register for rise detection.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_a <= scan_clk;
            sync_q <= sync_a;
            edge_q <= sync_q;
        end
    end

    assign tick        = sync_q & ~edge_q;
    assign frame_start = tick && (digit_sel == 2'd3);

    // Stage new frames in pending; promote to active only when a new frame begins.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pending_val <= '0;
            pending_dp  <= '0;
            pending_lz  <= 1'b0;
            active_val  <= '0;
            active_dp   <= '0;
            active_lz   <= 1'b0;
        end else begin
            if (load) begin
                pending_val <= value_in;
                pending_dp  <= dp_in;
                pending_lz  <= blank_lz;
            end
            if (frame_start) begin
                active_val <= load ? value_in : pending_val;
                active_dp  <= load ? dp_in    : pending_dp;
                active_lz  <= load ? blank_lz : pending_lz;
            end
        end
    end

    // upper_zero[i]: digit i and every digit above it are zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_upper_zero
            assign upper_zero[gi] = (active_val[15:4*gi] == '0);
        end
    endgenerate

    assign shifted_val = active_val >> {digit_sel, 2'b00};
    assign nibble      = shifted_val[3:0];
    assign lz_blank    = active_lz && (digit_sel != 2'd0) && upper_zero[digit_sel];

    // Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
    always_comb begin
        hex_seg = 7'h7F;
        case (nibble)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            4'hF: hex_seg = 7'h0E;
            default: hex_seg = 7'h7F;
        endcase
    end

    // Output pattern for the selected digit; a suppressed leading zero stays dark.
    always_comb begin
        show_an  = lz_blank ? 4'hF  : ~(4'b0001 << digit_sel);
        show_seg = lz_blank ? 7'h7F : hex_seg;
        show_dp  = lz_blank ? 1'b1  : ~active_dp[digit_sel];
    end

    // Scan FSM: every tick blanks the display and selects the next digit,
    // the gap counter then runs down before the digit is lit.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= OFF;
            cnt       <= '0;
            digit_sel <= 2'd3;
            an        <= 4'hF;
            seg       <= 7'h7F;
            dp        <= 1'b1;
        end else if (tick) begin
            state     <= BLANK;
            cnt       <= CNT_W'(BLANK_CYCLES);
            digit_sel <= digit_sel + 2'd1;
            an        <= 4'hF;
            seg       <= 7'h7F;
            dp        <= 1'b1;
        end else begin
            case (state)
                OFF: begin
                    an  <= 4'hF;
                    seg <= 7'h7F;
                    dp  <= 1'b1;
                end
                BLANK: begin
                    if (cnt == '0) begin
                        state <= SHOW;
                        an    <= show_an;
                        seg   <= show_seg;
                        dp    <= show_dp;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SHOW: begin
                    state <= SHOW;
                end
                default: begin
                    state <= OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: a frame-level reference model
// pushes the expected digit image on every scan_clk rise; an independent
// monitor pops and compares when the DUT selects a new digit.
module tb_seg7_scan_driver;

    localparam int BLANK = 8;
    localparam int CW    = 8;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b1;
    logic        scan_clk = 1'b0;
    logic [15:0] value_in = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_sel;

    seg7_scan_driver #(.BLANK_CYCLES(BLANK), .CNT_W(CW)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .scan_clk  (scan_clk),
        .value_in  (value_in),
        .load      (load),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .digit_sel (digit_sel)
    );

    always #4 clk_in = ~clk_in;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    logic [6:0] hex_tab [16];

    // Reference model state: what has been loaded and what is on display.
    logic [15:0] m_pend_v = '0, m_act_v = '0;
    logic [3:0]  m_pend_dp = '0, m_act_dp = '0;
    logic        m_pend_lz = 1'b0, m_act_lz = 1'b0;
    int          m_digit = 3;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    function automatic exp_t model_image(input int d);
        exp_t e;
        logic [15:0] upper;
        logic        blank;
        logic [3:0]  nib;
        upper = m_act_v >> (4 * d);
        nib   = upper[3:0];
        blank = m_act_lz && (d > 0) && (upper == 16'h0);
        e.sel = 2'(d);
        e.an  = blank ? 4'hF : ~(4'b0001 << d);
        e.seg = blank ? 7'h7F : hex_tab[nib];
        e.dp  = blank ? 1'b1 : ~m_act_dp[d];
        return e;
    endfunction

    // Advance the model one digit; a wrap to digit 0 starts a new frame.
    function automatic exp_t model_advance();
        m_digit = (m_digit + 1) % 4;
        if (m_digit == 0) begin
            m_act_v  = m_pend_v;
            m_act_dp = m_pend_dp;
            m_act_lz = m_pend_lz;
        end
        return model_image(m_digit);
    endfunction

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
        value_in  = v;
        dp_in     = d;
        blank_lz  = lz;
        load      = 1'b1;
        m_pend_v  = v;
        m_pend_dp = d;
        m_pend_lz = lz;
        step(1);
        load = 1'b0;
        step(2);
    endtask

    task automatic scan_tick(input int half);
        exp_t e;
        scan_clk = 1'b1;
        e = model_advance();
        sb.push_back(e);
        step(half);
        scan_clk = 1'b0;
        step(half);
    endtask

    // Monitor: on each new digit selection, check the gap length and the lit image.
    initial begin : monitor
        logic [1:0] prev;
        exp_t       e;
        int         fcnt;
        prev = 2'd3;
        forever begin
            @(negedge clk_in);
            if (digit_sel != prev) begin
                prev = digit_sel;
                if (mon_en) begin
                    fcnt = 0;
                    for (int k = 0; k < BLANK + 1; k++) begin
                        if (k > 0) @(negedge clk_in);
                        if (an == 4'hF) fcnt++;
                    end
                    @(negedge clk_in);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: got digit_sel %0d expected no output at %0t", digit_sel, $time);
                    end else begin
                        e = sb.pop_front();
                        chk("gap_cycles", fcnt, BLANK + 1);
                        chk("digit_sel", int'(digit_sel), int'(e.sel));
                        chk("an", int'(an), int'(e.an));
                        chk("seg", int'(seg), int'(e.seg));
                        chk("dp", int'(dp), int'(e.dp));
                        $display("digit %0d: an=%h seg=%h dp=%b", digit_sel, an, seg, dp);
                    end
                    prev = digit_sel;
                end
            end
        end
    end

    initial begin : stimulus
        exp_t        e2;
        int          fcnt;
        int          waited;
        logic [15:0] v;
        int          sel_before;

        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // Reset held while scan_clk toggles: outputs must stay at reset values.
        for (int i = 0; i < 3; i++) begin
            step(1);
            scan_clk = 1'b1;
            step(5);
            chk("rst_an", int'(an), 4'hF);
            chk("rst_seg", int'(seg), 7'h7F);
            chk("rst_dp", int'(dp), 1);
            chk("rst_sel", int'(digit_sel), 3);
            scan_clk = 1'b0;
            step(5);
        end
        rst = 1'b0;
        step(3);
        mon_en = 1'b1;

        // Plain display with one decimal point.
        do_load(16'h12AF, 4'b0100, 1'b0);
        for (int i = 0; i < 4; i++) scan_tick(15);

        // Leading-zero suppression.
        do_load(16'h0007, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) scan_tick(15);

        // A load in mid-frame must not tear the frame on display.
        do_load(16'h1111, 4'b0000, 1'b0);
        scan_tick(15);
        scan_tick(15);
        do_load(16'h2222, 4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) scan_tick(15);

        // Randomised frames with occasional loads and random scan rates.
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                v = 16'($urandom);
                v = v & (16'hFFFF >> (4 * $urandom_range(0, 3)));
                do_load(v, 4'($urandom), 1'($urandom));
            end
            scan_tick($urandom_range(12, 25));
        end

        // Fix a fully lit frame before the gap-restart check.
        do_load(16'h12AF, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) scan_tick(15);

        // Two ticks 4 cycles apart: the second must restart the full gap.
        mon_en = 1'b0;
        step(2);
        scan_clk = 1'b1;
        e2 = model_advance();
        step(2);
        scan_clk = 1'b0;
        step(2);
        scan_clk = 1'b1;
        e2 = model_advance();
        waited = 0;
        while (digit_sel != e2.sel && waited < 40) begin
            @(negedge clk_in);
            waited++;
        end
        chk("restart_sel_reached", int'(digit_sel), int'(e2.sel));
        fcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (an != 4'hF) break;
            fcnt++;
            @(negedge clk_in);
        end
        chk("restart_gap", fcnt, BLANK + 1);
        chk("restart_an", int'(an), int'(e2.an));
        chk("restart_seg", int'(seg), int'(e2.seg));
        $display("restart: gap=%0d an=%h seg=%h", fcnt, an, seg);
        step(10);
        scan_clk = 1'b0;
        step(20);

        // Walk to digit 2 on display, then reset asynchronously mid-cycle.
        mon_en = 1'b1;
        while (m_digit != 2) scan_tick(15);
        mon_en = 1'b0;
        sel_before = int'(digit_sel);
        chk("pre_rst_sel", sel_before, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_an", int'(an), 4'hF);
        chk("async_rst_seg", int'(seg), 7'h7F);
        chk("async_rst_dp", int'(dp), 1);
        chk("async_rst_sel", int'(digit_sel), 3);
        step(1);
        scan_clk = 1'b1;
        step(4);
        scan_clk = 1'b0;
        step(4);
        chk("rst_hold_an", int'(an), 4'hF);
        rst = 1'b0;
        m_pend_v = '0;  m_act_v = '0;
        m_pend_dp = '0; m_act_dp = '0;
        m_pend_lz = 1'b0; m_act_lz = 1'b0;
        m_digit = 3;
        sb.delete();
        step(3);
        mon_en = 1'b1;
        scan_tick(15);
        scan_tick(15);

        // scan_clk static: nothing may change.
        mon_en = 1'b0;
        step(40);
        chk("static_sel", int'(digit_sel), 1);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
